run_ctrl: RTL and testbench
===========================

# run_ctrl

Parametrised run controller that sequences a processor run in place of hand-toggled clock/reset stimulus: holds cores in reset, releases them, and gates execution per core through clock enables. Supports free-run, single-step and run-to-count modes, and terminates on all-cores-halted, cycle limit or abort. Sits between the top-level harness (or debug host) and one or more processor cores, and reports cycle count and a termination status.

## Interface
- `N_CORES`, 1: number of gated cores (channels).
- `CNT_W`, 32: width of the cycle counter and `max_cycles`.
- `RESET_CYCLES`, 1: cycles `core_rst` is held after start; must be ≥1.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; accepted only in IDLE or DONE.
- `mode`  in  2  00 free-run, 01 single-step, 10 run-to-count, 11 reserved; latched at start.
- `max_cycles`  in  CNT_W  cycle limit for run-to-count; latched at start.
- `step`  in  1  single-step request.
- `abort`  in  1  terminate the active run.
- `halt_req`  in  N_CORES  core i reports halt.
- `core_rst`  out  1  active-high synchronous reset to the cores.
- `core_en`  out  N_CORES  per-core execution enable.
- `cycle_cnt`  out  CNT_W  enabled cycles in the current/last run.
- `busy`  out  1  high in RESET, RUN, STEP.
- `done`  out  1  high in DONE.
- `status`  out  2  00 none, 01 all halted, 10 count reached, 11 aborted.

## Operation
- States: IDLE, RESET, RUN, STEP, DONE. Encodings and mode/status codes live in the shared constants.
- IDLE/DONE + `start`, with mode ≠ 11 → RESET. Clears `cycle_cnt`, `status` and the halted mask, and latches `mode`/`max_cycles`. With mode = 11, `start` is ignored.
- RESET: `core_rst`=1, `core_en`=0 for RESET_CYCLES cycles, then → RUN (modes 00/10) or STEP (01).
- RUN: `core_en` = ~halted.
  - `halt_req[i]` sampled while `core_en[i]`=1 sets sticky `halted[i]`.
  - `halt_req` of an already-disabled core is ignored.
- STEP: `core_en`=0 until `step` is sampled high. Then `core_en` = ~halted for exactly one cycle. `step` is ignored during that cycle.
- `cycle_cnt` increments on every cycle in which any `core_en` bit is 1. It saturates at all-ones and the run continues.
- Termination → DONE. Priority: abort (11) > all halted (01) > count reached (10).
  - Count reached: mode 10 and `cycle_cnt` equals `max_cycles` after the increment.
  - `max_cycles`=0 in mode 10: RESET → DONE directly, `cycle_cnt`=0, no enable cycles.
- `abort` is honoured in RESET, RUN and STEP. In IDLE/DONE it is ignored.
- DONE: `core_rst`=0 and `core_en`=0, so core state stays observable. `status` and `cycle_cnt` hold until the next accepted start.

## Timing
- Reset values: state IDLE, `core_rst`=1, `core_en`=0, `cycle_cnt`=0, `busy`=0, `done`=0, `status`=00.
- Async reset mid-run returns to IDLE immediately. No status is retained.
- All outputs are registered:
  - `start` at edge n → `core_rst`=1 from n+1.
  - `core_en` first high at n+1+RESET_CYCLES.
- `halt_req[i]` at edge n → `core_en[i]`=0 from n+1. The halting cycle is counted.
- Last halt or count match at edge n → `done`=1, `busy`=0, `core_en`=0 from n+1.
- `abort` at edge n → DONE from n+1. Abort wins over a simultaneous halt or count match.
- `step` at edge n (in STEP) → one `core_en` pulse in cycle n+1.
- Simultaneous `start` and `abort` in DONE: `start` wins.

## Configuration
- `RUN_CTRL_STALL_CNT_EN` defined: adds output `stall_cnt[CNT_W-1:0]`.
  - Counts cycles in RUN/STEP where no `core_en` bit is high.
  - Cleared on accepted start, saturating, reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared constants file: state encodings, `mode` codes (`FREE`/`STEP`/`COUNT`/`RSVD`), `status` codes.
- Sub-module `run_ctrl_sat_cnt`: CNT_W saturating counter with clear and enable. Instantiated for `cycle_cnt` and, when enabled, `stall_cnt`.

## Test plan
- Mode 10, `max_cycles`=16, N_CORES=1, no halts → exactly 16 `core_en` cycles, `done`=1, `status`=10, `cycle_cnt`=16.
- Mode 00, N_CORES=2, `halt_req[0]` at cycle 5, `halt_req[1]` at cycle 9 → `core_en[0]` low from cycle 6, DONE after cycle 9, `status`=01, `cycle_cnt`=9.
- Mode 01, three `step` pulses spaced 4 cycles apart → three single-cycle `core_en` pulses, `cycle_cnt`=3, still `busy`.
- `abort` asserted in the same cycle as the final halt → `status`=11.
- Mode 10 with `max_cycles`=0 → DONE after RESET, `cycle_cnt`=0, `core_en` never high.
- `rst` low mid-run at cycle 7 → immediately IDLE, `core_rst`=1, `cycle_cnt`=0. Then a restart with `max_cycles`=4 → `cycle_cnt`=4, `status`=10.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared constants for the run controller: FSM state encoding, mode codes and
// termination status codes.
// Latency: n/a (constants only). Backpressure: n/a.
// Contents: state_e, MODE_* (run mode input codes), ST_* (status output codes).
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_HALTED = 2'b01;
    localparam logic [1:0] ST_COUNT  = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

endpackage

// File: rtl/run_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: value updates one cycle after clr_i/en_i. Backpressure: none.
// Ports: clk, rst (async active-low), clr_i (wins over en_i), en_i, cnt_o.
module run_ctrl_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds cores in reset, releases them, gates per-core execution
// (free-run / single-step / run-to-count) and reports cycle count and status.
// Latency: all outputs registered; start -> core_rst next cycle, core_en after
// RESET_CYCLES more. Backpressure: none; start only accepted in IDLE/DONE.
// Ports: clk, rst (async active-low), start, mode, max_cycles, step, abort,
// halt_req[N_CORES] in; core_rst, core_en[N_CORES], cycle_cnt, busy, done,
// status out. Optional stall_cnt output when RUN_CTRL_STALL_CNT_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int N_CORES      = 1,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   max_cycles,
    input  logic               step,
    input  logic               abort,
    input  logic [N_CORES-1:0] halt_req,
    output logic               core_rst,
    output logic [N_CORES-1:0] core_en,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               busy,
    output logic               done,
`ifdef RUN_CTRL_STALL_CNT_EN
    output logic [CNT_W-1:0]   stall_cnt,
`endif
    output logic [1:0]         status
);

    localparam int              RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RESET_CYCLES - 1);

    state_e             state_q;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   max_q;
    logic [N_CORES-1:0] halted_q;
    logic [RC_W-1:0]    rst_cnt_q;
    logic               core_rst_q;
    logic [N_CORES-1:0] core_en_q;
    logic               busy_q;
    logic               done_q;
    logic [1:0]         status_q;

    logic               start_ok;
    logic               any_en;
    logic [N_CORES-1:0] halted_d;
    logic [CNT_W-1:0]   cyc_inc;
    logic               fin;
    logic [1:0]         fin_st;

    assign start_ok = start && (mode != MODE_RSVD) &&
                      (state_q == S_IDLE || state_q == S_DONE);
    assign any_en   = |core_en_q;
    // Halts only latch for cores that were actually executing this cycle.
    assign halted_d = halted_q | (halt_req & core_en_q);
    // Value cycle_cnt takes at this edge if the cycle is counted.
    assign cyc_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    // Termination detection, priority abort > all halted > count reached.
    always_comb begin
        fin    = 1'b0;
        fin_st = ST_NONE;
        case (state_q)
            S_RESET: begin
                if (abort) begin
                    fin    = 1'b1;
                    fin_st = ST_ABORT;
                end else if (rst_cnt_q == '0 && mode_q == MODE_COUNT && max_q == '0) begin
                    // Zero-length counted run ends without a single enable cycle.
                    fin    = 1'b1;
                    fin_st = ST_COUNT;
                end
            end
            S_RUN, S_STEP: begin
                if (abort) begin
                    fin    = 1'b1;
                    fin_st = ST_ABORT;
                end else if (&halted_d) begin
                    fin    = 1'b1;
                    fin_st = ST_HALTED;
                end else if (mode_q == MODE_COUNT && any_en && cyc_inc == max_q) begin
                    fin    = 1'b1;
                    fin_st = ST_COUNT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_FREE;
            max_q      <= '0;
            halted_q   <= '0;
            rst_cnt_q  <= '0;
            core_rst_q <= 1'b1;
            core_en_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= ST_NONE;
        end else if (fin) begin
            state_q    <= S_DONE;
            halted_q   <= halted_d;
            core_rst_q <= 1'b0;
            core_en_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            status_q   <= fin_st;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state_q    <= S_RESET;
                        mode_q     <= mode;
                        max_q      <= max_cycles;
                        halted_q   <= '0;
                        rst_cnt_q  <= RST_LOAD;
                        core_rst_q <= 1'b1;
                        core_en_q  <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        status_q   <= ST_NONE;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q != '0) begin
                        rst_cnt_q <= rst_cnt_q - RC_W'(1);
                    end else begin
                        core_rst_q <= 1'b0;
                        if (mode_q == MODE_STEP) begin
                            state_q   <= S_STEP;
                            core_en_q <= '0;
                        end else begin
                            state_q   <= S_RUN;
                            core_en_q <= ~halted_q;
                        end
                    end
                end
                S_RUN: begin
                    halted_q  <= halted_d;
                    core_en_q <= ~halted_d;
                end
                S_STEP: begin
                    halted_q <= halted_d;
                    // A non-zero enable marks the pulse cycle, during which step is ignored.
                    if (!any_en && step) begin
                        core_en_q <= ~halted_d;
                    end else begin
                        core_en_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    run_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_ok),
        .en_i  (any_en),
        .cnt_o (cycle_cnt)
    );

`ifdef RUN_CTRL_STALL_CNT_EN
    run_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_ok),
        .en_i  ((state_q == S_RUN || state_q == S_STEP) && !any_en),
        .cnt_o (stall_cnt)
    );
`endif

    assign core_rst = core_rst_q;
    assign core_en  = core_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign status   = status_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: directed scenarios plus randomized runs checked
// against a run-level model (enable windows, termination cycle and status
// derived from halt/abort/limit schedules).
module tb_run_ctrl;

    localparam int NC  = 2;
    localparam int CW  = 8;
    localparam int RC  = 2;
    localparam int INF = 1 << 30;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [CW-1:0] max_cycles;
    logic          step;
    logic          abort;
    logic [NC-1:0] halt_req;
    logic          core_rst;
    logic [NC-1:0] core_en;
    logic [CW-1:0] cycle_cnt;
    logic          busy;
    logic          done;
    logic [1:0]    status;
`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] last_st;
    int         last_cnt;

    always #5 clk = ~clk;

    run_ctrl #(.N_CORES(NC), .CNT_W(CW), .RESET_CYCLES(RC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .max_cycles (max_cycles),
        .step       (step),
        .abort      (abort),
        .halt_req   (halt_req),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .cycle_cnt  (cycle_cnt),
        .busy       (busy),
        .done       (done),
`ifdef RUN_CTRL_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .status     (status)
    );

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_phase();
        for (int r = 0; r < RC; r++) begin
            @(negedge clk);
            chk("rst_phase.core_rst", 32'(core_rst), 1);
            chk("rst_phase.core_en", 32'(core_en), 0);
            chk("rst_phase.busy", 32'(busy), 1);
            chk("rst_phase.cnt", 32'(cycle_cnt), 0);
            chk("rst_phase.status", 32'(status), 0);
            tick();
        end
    endtask

    // One run in free/count mode. h0/h1: enabled-cycle index at which core
    // raises halt (0 = never). ab: cycle index of abort (0 = none).
    task automatic run_case(input logic [1:0] md, input int mx, input int h0, input int h1,
                            input int ab, input bit ab_with_start);
        int h[NC];
        int hall, cntm, end_k;
        logic [1:0]    est;
        logic [NC-1:0] en_exp;
        h[0] = h0;
        h[1] = h1;
        hall  = (h0 > 0 && h1 > 0) ? ((h0 > h1) ? h0 : h1) : INF;
        cntm  = (md == 2'b10) ? mx : INF;
        end_k = (ab > 0) ? ab : INF;
        if (hall < end_k) end_k = hall;
        if (cntm < end_k) end_k = cntm;
        if (ab > 0 && ab == end_k)  est = 2'b11;
        else if (hall == end_k)     est = 2'b01;
        else                        est = 2'b10;

        mode       = md;
        max_cycles = CW'(mx);
        start      = 1'b1;
        abort      = ab_with_start;
        tick();
        start      = 1'b0;
        abort      = 1'b0;
        // Latched at start; changing them afterwards must not matter.
        mode       = 2'($urandom);
        max_cycles = CW'($urandom);
        chk_reset_phase();

        for (int k = 1; k <= end_k; k++) begin
            for (int i = 0; i < NC; i++) begin
                en_exp[i] = (h[i] == 0 || k <= h[i]);
                if (h[i] == k)                 halt_req[i] = 1'b1;
                else if (h[i] > 0 && k > h[i]) halt_req[i] = 1'($urandom_range(0, 1));
                else                           halt_req[i] = 1'b0;
            end
            abort = (k == ab);
            @(negedge clk);
            chk("run.core_en", 32'(core_en), 32'(en_exp));
            chk("run.cnt", 32'(cycle_cnt), sat(k - 1));
            chk("run.busy", 32'(busy), 1);
            chk("run.core_rst", 32'(core_rst), 0);
            tick();
        end
        halt_req = '0;
        abort    = 1'b0;
        @(negedge clk);
        chk("end.done", 32'(done), 1);
        chk("end.busy", 32'(busy), 0);
        chk("end.core_en", 32'(core_en), 0);
        chk("end.core_rst", 32'(core_rst), 0);
        chk("end.status", 32'(status), 32'(est));
        chk("end.cnt", 32'(cycle_cnt), sat(end_k));
        // Abort and halts in DONE must leave the result untouched.
        abort    = 1'($urandom_range(0, 1));
        halt_req = NC'($urandom);
        tick();
        abort    = 1'b0;
        halt_req = '0;
        @(negedge clk);
        chk("hold.status", 32'(status), 32'(est));
        chk("hold.cnt", 32'(cycle_cnt), sat(end_k));
        chk("hold.done", 32'(done), 1);
        last_st  = est;
        last_cnt = sat(end_k);
    endtask

    // Single-step run of n pulses, terminated by abort.
    task automatic step_case(input int n);
        int gap;
        mode  = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 2'($urandom);
        chk_reset_phase();
        for (int s = 0; s < n; s++) begin
            gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                halt_req = NC'($urandom);
                @(negedge clk);
                chk("step.idle_en", 32'(core_en), 0);
                chk("step.idle_cnt", 32'(cycle_cnt), s);
                chk("step.busy", 32'(busy), 1);
                tick();
            end
            halt_req = '0;
            step     = 1'b1;
            @(negedge clk);
            chk("step.req_en", 32'(core_en), 0);
            tick();
            step = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("step.pulse_en", 32'(core_en), {NC{1'b1}});
            chk("step.pulse_cnt", 32'(cycle_cnt), s);
            tick();
            step = 1'b0;
            @(negedge clk);
            chk("step.after_en", 32'(core_en), 0);
            chk("step.after_cnt", 32'(cycle_cnt), s + 1);
            tick();
        end
        @(negedge clk);
        chk("step.still_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("step.done", 32'(done), 1);
        chk("step.status", 32'(status), 3);
        chk("step.cnt", 32'(cycle_cnt), n);
        last_st  = 2'b11;
        last_cnt = n;
    endtask

    logic [1:0] r_md;
    int         r_mx, r_h0, r_h1, r_ab;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        step       = 1'b0;
        abort      = 1'b0;
        mode       = 2'b00;
        max_cycles = '0;
        halt_req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.core_rst", 32'(core_rst), 1);
        chk("reset.core_en", 32'(core_en), 0);
        chk("reset.cnt", 32'(cycle_cnt), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.done", 32'(done), 0);
        chk("reset.status", 32'(status), 0);
        tick();
        rst = 1'b1;

        // Reserved mode: start ignored in IDLE.
        mode  = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("rsvd_idle.busy", 32'(busy), 0);
        chk("rsvd_idle.core_rst", 32'(core_rst), 1);
        chk("rsvd_idle.done", 32'(done), 0);

        run_case(2'b10, 16, 0, 0, 0, 1'b0);   // count to 16
        run_case(2'b00, 0, 5, 9, 0, 1'b0);    // staggered halts
        step_case(3);
        run_case(2'b00, 0, 4, 7, 7, 1'b0);    // abort with final halt
        run_case(2'b10, 0, 0, 0, 0, 1'b0);    // zero-length count run
        run_case(2'b10, 5, 0, 0, 0, 1'b1);    // start beats abort in DONE
        run_case(2'b10, 6, 6, 3, 0, 1'b0);    // halt beats count match

        // Reserved mode: start ignored in DONE, result held.
        mode  = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("rsvd_done.done", 32'(done), 1);
        chk("rsvd_done.status", 32'(status), 32'(last_st));
        chk("rsvd_done.cnt", 32'(cycle_cnt), last_cnt);

        run_case(2'b00, 0, 0, 0, 260, 1'b0);  // counter saturation

        // Async reset in the middle of a run.
        mode       = 2'b10;
        max_cycles = CW'(20);
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (RC + 7) tick();
        #2 rst = 1'b0;
        #1;
        chk("arst.core_rst", 32'(core_rst), 1);
        chk("arst.cnt", 32'(cycle_cnt), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.done", 32'(done), 0);
        chk("arst.status", 32'(status), 0);
        chk("arst.core_en", 32'(core_en), 0);
        tick();
        rst = 1'b1;
        tick();
        run_case(2'b10, 4, 0, 0, 0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            r_md = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            r_mx = $urandom_range(0, 15);
            r_h0 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            r_h1 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            r_ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            if (r_md == 2'b00 && (r_h0 == 0 || r_h1 == 0) && r_ab == 0)
                r_ab = $urandom_range(1, 15);
            run_case(r_md, r_mx, r_h0, r_h1, r_ab, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
